fir_out_buffer: RTL and testbench

- Receiving end of the FIR sample stream: captures the filter's DOUT/VOUT output (valid-only, no backpressure) into a FIFO.
- Re-issues the samples on a ready/valid port so a slower consumer (checker, serializer, output logger) can drain them.
- Tracks total accepted samples and flags overflow when the filter outruns the consumer.
- Sits directly after filter_top in the datapath.

---
 rtl/filter_pkg.sv | 11 +
 rtl/fir_buf_mem.sv | 25 ++
 rtl/fir_out_buffer.sv | 105 ++++++++++
 tb/tb_fir_out_buffer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared constants and types for the FIR datapath.
package filter_pkg;

   localparam int SAMPLE_W   = 8;
   localparam int FILTER_NT  = 10;
   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_buf_mem.sv
// Sample storage for the output buffer: one synchronous write port, one asynchronous read port.
module fir_buf_mem #(
   parameter int NB    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk_i,
   input  logic          wrEn_i,
   input  logic [AW-1:0] wrAddr_i,
   input  logic [NB-1:0] wrData_i,
   input  logic [AW-1:0] rdAddr_i,
   output logic [NB-1:0] rdData_o
);

   logic [NB-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/fir_out_buffer.sv
// First-word-fall-through FIFO that catches the filter output stream and re-issues it
// on a ready/valid port, counting accepted samples and flagging drops when full.
module fir_out_buffer
   import filter_pkg::*;
#(
   parameter int NB    = SAMPLE_W,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW,
   parameter int CW    = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          VIN,
   input  logic [NB-1:0] DIN,
   output logic          VOUT,
   output logic [NB-1:0] DOUT,
   input  logic          RDY,
   output logic [AW:0]   CNT,
   output logic          OVF,
   input  logic          CLR_OVF,
   output logic [CW-1:0] NSAMP
);

   localparam logic [AW:0]   FullCnt  = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] NsampMax = '1;

   logic [AW-1:0] headPtr_q, headPtr_d;
   logic [AW-1:0] tailPtr_q, tailPtr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] nsamp_q, nsamp_d;
   logic [NB-1:0] lastDout_q, lastDout_d;
   logic [NB-1:0] memRdata;
   logic          rd, wr, drop, full, notEmpty;

   assign notEmpty = (cnt_q != '0);
   assign full     = (cnt_q == FullCnt);
   assign rd       = notEmpty & RDY;
   assign wr       = VIN & (~full | rd);
   assign drop     = VIN & full & ~rd;

   fir_buf_mem #(
      .NB    (NB),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i    (CLK),
      .wrEn_i   (wr),
      .wrAddr_i (tailPtr_q),
      .wrData_i (DIN),
      .rdAddr_i (headPtr_q),
      .rdData_o (memRdata)
   );

   // Overflow set takes priority over a same-edge clear so a drop is never lost.
   always_comb begin
      headPtr_d  = headPtr_q;
      tailPtr_d  = tailPtr_q;
      cnt_d      = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
      ovf_d      = ovf_q;
      nsamp_d    = nsamp_q;
      lastDout_d = lastDout_q;
      if (rd) begin
         headPtr_d  = headPtr_q + AW'(1);
         lastDout_d = memRdata;
      end
      if (wr) begin
         tailPtr_d = tailPtr_q + AW'(1);
         if (nsamp_q != NsampMax) begin
            nsamp_d = nsamp_q + CW'(1);
         end
      end
      if (drop) begin
         ovf_d = 1'b1;
      end else if (CLR_OVF) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         headPtr_q  <= '0;
         tailPtr_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         nsamp_q    <= '0;
         lastDout_q <= '0;
      end else begin
         headPtr_q  <= headPtr_d;
         tailPtr_q  <= tailPtr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         nsamp_q    <= nsamp_d;
         lastDout_q <= lastDout_d;
      end
   end

   // While empty, DOUT keeps showing the most recently consumed sample.
   assign VOUT  = notEmpty;
   assign DOUT  = notEmpty ? memRdata : lastDout_q;
   assign CNT   = cnt_q;
   assign OVF   = ovf_q;
   assign NSAMP = nsamp_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer; a narrow sample counter is used so saturation is reached.
module tb_fir_out_buffer;

   localparam int NB    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int CW    = 8;
   localparam int NSMAX = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          VIN = 1'b0;
   logic [NB-1:0] DIN = '0;
   logic          VOUT;
   logic [NB-1:0] DOUT;
   logic          RDY = 1'b0;
   logic [AW:0]   CNT;
   logic          OVF;
   logic          CLR_OVF = 1'b0;
   logic [CW-1:0] NSAMP;

   logic [NB-1:0] expQ[$];
   int            mCount = 0;
   int            mNsamp = 0;
   bit            mOvf   = 1'b0;
   int            nChecks = 0;
   int            nFails  = 0;

   fir_out_buffer #(.NB(NB), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .VIN     (VIN),
      .DIN     (DIN),
      .VOUT    (VOUT),
      .DOUT    (DOUT),
      .RDY     (RDY),
      .CNT     (CNT),
      .OVF     (OVF),
      .CLR_OVF (CLR_OVF),
      .NSAMP   (NSAMP)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, predicts the edge outcome and checks the registered state after it.
   task automatic applyStimulus(input bit vin, input logic [NB-1:0] din, input bit rdy, input bit clr);
      bit            rd, wr;
      logic [NB-1:0] exp;
      @(negedge CLK);
      VIN = vin; DIN = din; RDY = rdy; CLR_OVF = clr;
      #1;
      checkOutput("vout", 32'(VOUT), 32'(mCount > 0));
      rd = (mCount > 0) && rdy;
      if (rd) begin
         exp = expQ.pop_front();
         checkOutput("dout", 32'(DOUT), 32'(exp));
      end
      wr = vin && ((mCount < DEPTH) || rd);
      if (wr) begin
         expQ.push_back(din);
         if (mNsamp < NSMAX) mNsamp++;
      end
      if (vin && !wr) mOvf = 1'b1;
      else if (clr)   mOvf = 1'b0;
      mCount = mCount + int'(wr) - int'(rd);
      @(posedge CLK);
      #1;
      checkOutput("cnt",   32'(CNT),   32'(mCount));
      checkOutput("ovf",   32'(OVF),   32'(mOvf));
      checkOutput("nsamp", 32'(NSAMP), 32'(mNsamp));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_cnt"},   32'(CNT),   32'd0);
      checkOutput({tag, "_vout"},  32'(VOUT),  32'd0);
      checkOutput({tag, "_dout"},  32'(DOUT),  32'd0);
      checkOutput({tag, "_ovf"},   32'(OVF),   32'd0);
      checkOutput({tag, "_nsamp"}, 32'(NSAMP), 32'd0);
   endtask

   initial begin
      #12;
      checkResetState("rst");
      RST = 1'b0;

      // Single negative sample appears at the head after one edge.
      applyStimulus(1'b1, 8'hFB, 1'b0, 1'b0);
      checkOutput("first_vout", 32'(VOUT), 32'd1);
      checkOutput("first_dout", 32'(DOUT), 32'hFB);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

      // Fill 1..16, then a 17th sample that must be dropped.
      for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd99, 1'b0, 1'b0);
      checkOutput("full_ovf", 32'(OVF), 32'd1);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

      // Full FIFO with simultaneous read and write accepts the write.
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(100 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd77, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

      // Streaming ramp through an empty FIFO; NSAMP saturates along the way.
      for (int v = -128; v <= 127; v++) applyStimulus(1'b1, 8'(v), 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("nsamp_sat", 32'(NSAMP), 32'(NSMAX));

      // Drop coinciding with a clear keeps OVF set; a clear alone then clears it.
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(200 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd50, 1'b0, 1'b1);
      checkOutput("ovf_setwins", 32'(OVF), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("ovf_cleared", 32'(OVF), 32'd0);

      // Mid-stream asynchronous reset with CNT=9 and OVF=1.
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("pre_rst_cnt", 32'(CNT), 32'd9);
      checkOutput("pre_rst_ovf", 32'(OVF), 32'd1);
      #2 RST = 1'b1;
      #1 checkResetState("async_rst");
      #1 RST = 1'b0;
      expQ.delete();
      mCount = 0;
      mNsamp = 0;
      mOvf   = 1'b0;
      applyStimulus(1'b1, 8'd33, 1'b0, 1'b0);
      checkOutput("post_rst_vout", 32'(VOUT), 32'd1);
      checkOutput("post_rst_dout", 32'(DOUT), 32'd33);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
